// File: rtl/bus_arbiter.sv
// ============================================================================
// Module   : bus_arbiter
// Brief    : Round-robin fetch/data arbiter with memory-map decode and watchdog
// Revision : 1.0
// ============================================================================
`default_nettype none

module bus_arbiter #(
    parameter logic [31:0] ROM_BASE       = 32'h0000_0000,
    parameter logic [31:0] ROM_TOP        = 32'h0000_0080,
    parameter logic [31:0] UART_BASE      = 32'h0100_0000,
    parameter logic [31:0] UART_TOP       = 32'h0100_0004,
    parameter logic [31:0] CLINT_BASE     = 32'h0200_0000,
    parameter logic [31:0] CLINT_TOP      = 32'h0200_C000,
    parameter logic [31:0] AXI_BASE       = 32'h8000_0000,
    parameter logic [31:0] AXI_TOP        = 32'h9000_0000,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_valid,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    output logic        i_error,
    input  logic        d_valid,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        d_error,
    output logic        m_valid,
    output logic        m_instr,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic [3:0]  m_sel,
    input  logic [31:0] m_rdata,
    input  logic        m_ready
);

    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_ERR  = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    // Offset-from-base compare gives base <= a < top in a single unsigned test.
    function automatic logic [3:0] decode(input logic [31:0] a);
        logic [3:0] s;
        s = 4'b0000;
        if ((a - ROM_BASE) < (ROM_TOP - ROM_BASE))
            s = 4'b0001;
        else if ((a - UART_BASE) < (UART_TOP - UART_BASE))
            s = 4'b0010;
        else if ((a - CLINT_BASE) < (CLINT_TOP - CLINT_BASE))
            s = 4'b0100;
        else if ((a - AXI_BASE) < (AXI_TOP - AXI_BASE))
            s = 4'b1000;
        return s;
    endfunction

    logic [1:0]      state_q, state_d;
    logic            last_instr_q, last_instr_d;
    logic            m_instr_q, m_instr_d;
    logic [31:0]     m_addr_q, m_addr_d;
    logic [31:0]     m_wdata_q, m_wdata_d;
    logic [3:0]      m_wstrb_q, m_wstrb_d;
    logic [3:0]      m_sel_q, m_sel_d;
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            i_ready_q, i_ready_d;
    logic            i_error_q, i_error_d;
    logic [31:0]     i_rdata_q, i_rdata_d;
    logic            d_ready_q, d_ready_d;
    logic            d_error_q, d_error_d;
    logic [31:0]     d_rdata_q, d_rdata_d;

    logic            w_grant_instr;
    logic [31:0]     w_gaddr;
    logic [3:0]      w_gsel;
    logic            w_fin;
    logic            w_fin_err;
    logic [31:0]     w_fin_data;

    // With both requesting, the port that did not win last time gets the bus.
    assign w_grant_instr = i_valid && (!d_valid || !last_instr_q);
    assign w_gaddr       = w_grant_instr ? i_addr : d_addr;
    assign w_gsel        = decode(w_gaddr);

    always_comb begin
        state_d      = state_q;
        last_instr_d = last_instr_q;
        m_instr_d    = m_instr_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        m_wstrb_d    = m_wstrb_q;
        m_sel_d      = m_sel_q;
        wdog_d       = wdog_q;
        i_ready_d    = 1'b0;
        i_error_d    = 1'b0;
        i_rdata_d    = 32'h0;
        d_ready_d    = 1'b0;
        d_error_d    = 1'b0;
        d_rdata_d    = 32'h0;
        w_fin        = 1'b0;
        w_fin_err    = 1'b0;
        w_fin_data   = 32'h0;

        case (state_q)
            S_IDLE: begin
                if (i_valid || d_valid) begin
                    last_instr_d = w_grant_instr;
                    m_instr_d    = w_grant_instr;
                    m_addr_d     = w_gaddr;
                    m_wdata_d    = d_wdata;
                    m_wstrb_d    = w_grant_instr ? 4'b0000 : d_wstrb;
                    m_sel_d      = w_gsel;
                    wdog_d       = '0;
                    state_d      = (w_gsel != 4'b0000) ? S_BUSY : S_ERR;
                end
            end
            S_BUSY: begin
                if (m_ready) begin
                    w_fin      = 1'b1;
                    w_fin_data = m_rdata;
                end else if (wdog_q == WD_LAST) begin
                    w_fin     = 1'b1;
                    w_fin_err = 1'b1;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            S_ERR: begin
                w_fin     = 1'b1;
                w_fin_err = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (w_fin) begin
            state_d = S_RESP;
            m_sel_d = 4'b0000;
            wdog_d  = '0;
            if (m_instr_q) begin
                i_ready_d = 1'b1;
                i_error_d = w_fin_err;
                i_rdata_d = w_fin_data;
            end else begin
                d_ready_d = 1'b1;
                d_error_d = w_fin_err;
                d_rdata_d = w_fin_data;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            last_instr_q <= 1'b1;
            m_instr_q    <= 1'b0;
            m_addr_q     <= 32'h0;
            m_wdata_q    <= 32'h0;
            m_wstrb_q    <= 4'b0000;
            m_sel_q      <= 4'b0000;
            wdog_q       <= '0;
            i_ready_q    <= 1'b0;
            i_error_q    <= 1'b0;
            i_rdata_q    <= 32'h0;
            d_ready_q    <= 1'b0;
            d_error_q    <= 1'b0;
            d_rdata_q    <= 32'h0;
        end else begin
            state_q      <= state_d;
            last_instr_q <= last_instr_d;
            m_instr_q    <= m_instr_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            m_wstrb_q    <= m_wstrb_d;
            m_sel_q      <= m_sel_d;
            wdog_q       <= wdog_d;
            i_ready_q    <= i_ready_d;
            i_error_q    <= i_error_d;
            i_rdata_q    <= i_rdata_d;
            d_ready_q    <= d_ready_d;
            d_error_q    <= d_error_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign m_valid = (state_q == S_BUSY);
    assign m_instr = m_instr_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign m_wstrb = m_wstrb_q;
    assign m_sel   = m_sel_q;
    assign i_ready = i_ready_q;
    assign i_error = i_error_q;
    assign i_rdata = i_rdata_q;
    assign d_ready = d_ready_q;
    assign d_error = d_error_q;
    assign d_rdata = d_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// ============================================================================
// Module   : tb_bus_arbiter
// Brief    : Directed self-checking bench for bus_arbiter
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bus_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        i_valid = 1'b0;
    logic [31:0] i_addr = 32'h0;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        i_error;
    logic        d_valid = 1'b0;
    logic [31:0] d_addr = 32'h0;
    logic [31:0] d_wdata = 32'h0;
    logic [3:0]  d_wstrb = 4'h0;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        d_error;
    logic        m_valid;
    logic        m_instr;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic [3:0]  m_sel;
    logic [31:0] m_rdata = 32'h0;
    logic        m_ready;

    logic        auto_rdy = 1'b0;
    logic        man_rdy = 1'b0;
    int          checks = 0;
    int          failures = 0;

    assign m_ready = auto_rdy ? m_valid : man_rdy;

    always #5 clock = ~clock;

    bus_arbiter dut (
        .clock   (clock),
        .reset   (reset),
        .i_valid (i_valid),
        .i_addr  (i_addr),
        .i_rdata (i_rdata),
        .i_ready (i_ready),
        .i_error (i_error),
        .d_valid (d_valid),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_wstrb (d_wstrb),
        .d_rdata (d_rdata),
        .d_ready (d_ready),
        .d_error (d_error),
        .m_valid (m_valid),
        .m_instr (m_instr),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_wstrb (m_wstrb),
        .m_sel   (m_sel),
        .m_rdata (m_rdata),
        .m_ready (m_ready)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        i_valid = 1'b1;
        i_addr = 32'h0000_0004;
        tick;
        tick;
        checks++;
        if ({m_valid, m_instr, m_sel, m_wstrb} !== 10'h0) begin
            failures++;
            $display("FAIL reset_ctrl: got %h expected 0", {m_valid, m_instr, m_sel, m_wstrb});
        end
        checks++;
        if ({m_addr, m_wdata} !== 64'h0) begin
            failures++;
            $display("FAIL reset_data: got %h expected 0", {m_addr, m_wdata});
        end
        checks++;
        if ({i_ready, i_error, d_ready, d_error} !== 4'h0) begin
            failures++;
            $display("FAIL reset_resp: got %b expected 0000", {i_ready, i_error, d_ready, d_error});
        end
        checks++;
        if ({i_rdata, d_rdata} !== 64'h0) begin
            failures++;
            $display("FAIL reset_rdata: got %h expected 0", {i_rdata, d_rdata});
        end
        i_valid = 1'b0;
        reset = 1'b1;
        tick;
    endtask

    task automatic test_round_robin;
        logic        exp_instr;
        logic [31:0] exp_data;
        int          n;
        reset = 1'b0;
        i_valid = 1'b1;
        i_addr = 32'h0000_0010;
        d_valid = 1'b1;
        d_addr = 32'h8000_0000;
        d_wstrb = 4'h0;
        auto_rdy = 1'b1;
        tick;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_instr = (k % 2) == 1;
            exp_data = 32'hA5A5_0000 + 32'(k);
            m_rdata = exp_data;
            n = 0;
            while (m_valid !== 1'b1 && n < 10) begin
                tick;
                n++;
            end
            checks++;
            if (m_valid !== 1'b1) begin
                failures++;
                $display("FAIL rr_wait%0d: got m_valid=%b expected 1", k, m_valid);
            end
            checks++;
            if (m_instr !== exp_instr) begin
                failures++;
                $display("FAIL rr_grant%0d: got m_instr=%b expected %b", k, m_instr, exp_instr);
            end
            tick;
            checks++;
            if ({i_ready, d_ready} !== {exp_instr, !exp_instr}) begin
                failures++;
                $display("FAIL rr_ready%0d: got i/d=%b%b expected %b%b", k, i_ready, d_ready, exp_instr, !exp_instr);
            end
            checks++;
            if ((exp_instr ? i_rdata : d_rdata) !== exp_data) begin
                failures++;
                $display("FAIL rr_rdata%0d: got %h expected %h", k, exp_instr ? i_rdata : d_rdata, exp_data);
            end
            if (k == 3) begin
                i_valid = 1'b0;
                d_valid = 1'b0;
            end
            tick;
            checks++;
            if ({i_ready, d_ready} !== 2'b00) begin
                failures++;
                $display("FAIL rr_pulse%0d: got i/d=%b%b expected 00", k, i_ready, d_ready);
            end
        end
        auto_rdy = 1'b0;
        tick;
    endtask

    task automatic test_uart_read;
        d_valid = 1'b1;
        d_addr = 32'h0100_0000;
        d_wstrb = 4'h0;
        d_wdata = 32'h1111_2222;
        tick;
        checks++;
        if ({m_valid, m_instr, m_sel, m_wstrb} !== {1'b1, 1'b0, 4'b0010, 4'b0000}) begin
            failures++;
            $display("FAIL uart_req: got v/i/sel/strb=%b/%b/%b/%b expected 1/0/0010/0000", m_valid, m_instr, m_sel, m_wstrb);
        end
        checks++;
        if (m_addr !== 32'h0100_0000) begin
            failures++;
            $display("FAIL uart_addr: got %h expected 01000000", m_addr);
        end
        tick;
        tick;
        checks++;
        if ({m_valid, d_ready} !== 2'b10) begin
            failures++;
            $display("FAIL uart_wait: got v/rdy=%b%b expected 10", m_valid, d_ready);
        end
        man_rdy = 1'b1;
        m_rdata = 32'hCAFE_F00D;
        tick;
        man_rdy = 1'b0;
        checks++;
        if ({d_ready, d_error, i_ready, m_valid, m_sel} !== {4'b1000, 4'b0000}) begin
            failures++;
            $display("FAIL uart_resp: got rdy/err/irdy/v/sel=%b%b%b%b/%b expected 1000/0000", d_ready, d_error, i_ready, m_valid, m_sel);
        end
        checks++;
        if (d_rdata !== 32'hCAFE_F00D) begin
            failures++;
            $display("FAIL uart_rdata: got %h expected cafef00d", d_rdata);
        end
        d_valid = 1'b0;
        tick;
        checks++;
        if (d_ready !== 1'b0) begin
            failures++;
            $display("FAIL uart_pulse: got d_ready=%b expected 0", d_ready);
        end
    endtask

    task automatic test_axi_fetch;
        d_valid = 1'b1;
        d_addr = 32'h8000_0010;
        d_wdata = 32'hDEAD_BEEF;
        d_wstrb = 4'hF;
        tick;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({m_valid, m_sel, m_wstrb, m_addr, m_wdata} !== {1'b1, 4'b1000, 4'hF, 32'h8000_0010, 32'hDEAD_BEEF}) begin
                failures++;
                $display("FAIL axi_hold%0d: got v/sel/strb/addr/wdata=%b/%b/%h/%h/%h expected 1/1000/f/80000010/deadbeef",
                         k, m_valid, m_sel, m_wstrb, m_addr, m_wdata);
            end
            tick;
        end
        man_rdy = 1'b1;
        tick;
        man_rdy = 1'b0;
        checks++;
        if ({d_ready, d_error} !== 2'b10) begin
            failures++;
            $display("FAIL axi_resp: got rdy/err=%b%b expected 10", d_ready, d_error);
        end
        d_valid = 1'b0;
        tick;
        i_valid = 1'b1;
        i_addr = 32'h0000_007C;
        tick;
        checks++;
        if ({m_valid, m_instr, m_sel, m_wstrb} !== {1'b1, 1'b1, 4'b0001, 4'b0000}) begin
            failures++;
            $display("FAIL fetch_req: got v/i/sel/strb=%b/%b/%b/%b expected 1/1/0001/0000", m_valid, m_instr, m_sel, m_wstrb);
        end
        man_rdy = 1'b1;
        m_rdata = 32'h0000_0013;
        tick;
        man_rdy = 1'b0;
        checks++;
        if ({i_ready, i_error, d_ready, i_rdata} !== {3'b100, 32'h0000_0013}) begin
            failures++;
            $display("FAIL fetch_resp: got rdy/err/drdy/rdata=%b%b%b/%h expected 100/00000013", i_ready, i_error, d_ready, i_rdata);
        end
        i_valid = 1'b0;
        tick;
    endtask

    task automatic test_unmapped;
        m_rdata = 32'hFFFF_FFFF;
        d_valid = 1'b1;
        d_addr = 32'h0000_0080;
        d_wstrb = 4'h0;
        tick;
        checks++;
        if ({m_valid, d_ready} !== 2'b00) begin
            failures++;
            $display("FAIL unmap_d_mid: got v/rdy=%b%b expected 00", m_valid, d_ready);
        end
        tick;
        checks++;
        if ({m_valid, d_ready, d_error, d_rdata} !== {3'b011, 32'h0}) begin
            failures++;
            $display("FAIL unmap_d_resp: got v/rdy/err/rdata=%b%b%b/%h expected 011/00000000", m_valid, d_ready, d_error, d_rdata);
        end
        d_valid = 1'b0;
        tick;
        i_valid = 1'b1;
        i_addr = 32'h9000_0000;
        tick;
        checks++;
        if ({m_valid, i_ready} !== 2'b00) begin
            failures++;
            $display("FAIL unmap_i_mid: got v/rdy=%b%b expected 00", m_valid, i_ready);
        end
        tick;
        checks++;
        if ({m_valid, i_ready, i_error, d_ready, i_rdata} !== {4'b0110, 32'h0}) begin
            failures++;
            $display("FAIL unmap_i_resp: got v/rdy/err/drdy/rdata=%b%b%b%b/%h expected 0110/00000000", m_valid, i_ready, i_error, d_ready, i_rdata);
        end
        i_valid = 1'b0;
        tick;
    endtask

    task automatic test_timeout;
        int n;
        m_rdata = 32'h5555_5555;
        d_valid = 1'b1;
        d_addr = 32'h0200_0004;
        tick;
        n = 0;
        while (m_valid === 1'b1 && n < 1100) begin
            n++;
            tick;
        end
        checks++;
        if (n !== 1024) begin
            failures++;
            $display("FAIL tmo_cycles: got %0d expected 1024", n);
        end
        checks++;
        if ({m_valid, d_ready, d_error, d_rdata} !== {3'b011, 32'h0}) begin
            failures++;
            $display("FAIL tmo_resp: got v/rdy/err/rdata=%b%b%b/%h expected 011/00000000", m_valid, d_ready, d_error, d_rdata);
        end
        d_valid = 1'b0;
        tick;
        d_valid = 1'b1;
        d_addr = 32'h0200_BFFC;
        tick;
        checks++;
        if ({m_valid, m_sel} !== 5'b1_0100) begin
            failures++;
            $display("FAIL tmo_next_req: got v/sel=%b/%b expected 1/0100", m_valid, m_sel);
        end
        man_rdy = 1'b1;
        m_rdata = 32'h0000_ABCD;
        tick;
        man_rdy = 1'b0;
        checks++;
        if ({d_ready, d_error, d_rdata} !== {2'b10, 32'h0000_ABCD}) begin
            failures++;
            $display("FAIL tmo_next_resp: got rdy/err/rdata=%b%b/%h expected 10/0000abcd", d_ready, d_error, d_rdata);
        end
        d_valid = 1'b0;
        tick;
    endtask

    task automatic test_reset_mid;
        int n;
        d_valid = 1'b1;
        d_addr = 32'h0100_0000;
        tick;
        checks++;
        if (m_valid !== 1'b1) begin
            failures++;
            $display("FAIL rstm_busy: got m_valid=%b expected 1", m_valid);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({m_valid, m_sel, m_addr} !== 37'h0) begin
            failures++;
            $display("FAIL rstm_async: got v/sel/addr=%b/%b/%h expected 0/0000/00000000", m_valid, m_sel, m_addr);
        end
        man_rdy = 1'b1;
        tick;
        tick;
        checks++;
        if ({i_ready, d_ready} !== 2'b00) begin
            failures++;
            $display("FAIL rstm_noresp: got i/d=%b%b expected 00", i_ready, d_ready);
        end
        man_rdy = 1'b0;
        reset = 1'b1;
        auto_rdy = 1'b1;
        n = 0;
        while (m_valid !== 1'b1 && n < 5) begin
            tick;
            n++;
        end
        checks++;
        if ({m_valid, m_sel} !== 5'b1_0010) begin
            failures++;
            $display("FAIL rstm_serve: got v/sel=%b/%b expected 1/0010", m_valid, m_sel);
        end
        tick;
        checks++;
        if ({d_ready, d_error, i_ready} !== 3'b100) begin
            failures++;
            $display("FAIL rstm_resp: got rdy/err/irdy=%b%b%b expected 100", d_ready, d_error, i_ready);
        end
        d_valid = 1'b0;
        auto_rdy = 1'b0;
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        test_reset;
        test_round_robin;
        test_uart_read;
        test_axi_fetch;
        test_unmapped;
        test_timeout;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
